// File: rtl/dstack_guarded.sv
// LIFO stack with signed pointer step, TOS/NOS taps, exact depth and sticky ovf/unf flags.
// Define STACK_GUARD_EN to suppress pointer/depth/memory changes on error cycles.
module dstack_guarded #(
    parameter int saddr_width = 8,
    parameter int width       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wait_state,
    input  logic [width-1:0]       D,
    input  logic [1:0]             delta,
    input  logic                   update,
    input  logic                   clr_err,
    output logic [width-1:0]       T,
    output logic [width-1:0]       N,
    output logic [saddr_width:0]   depth,
    output logic                   empty,
    output logic                   full,
    output logic                   ovf,
    output logic                   unf
);
    localparam int DEPTH = 2 ** saddr_width;
    localparam logic [saddr_width:0] CAP = (saddr_width+1)'(DEPTH);
    localparam logic [saddr_width:0] TWO = (saddr_width+1)'(2);

    logic [width-1:0]       mem_q [DEPTH];
    logic [saddr_width-1:0] sp_q, sp_d, sp_step, sp_m1;
    logic [saddr_width:0]   depth_q, depth_d, depth_step, depth_nxt;
    logic                   ovf_q, ovf_d, unf_q, unf_d;
    logic                   ovf_err, unf_err, move, wr_en;

    assign sp_step    = saddr_width'($signed(delta));
    assign depth_step = (saddr_width+1)'($signed(delta));
    assign sp_m1      = sp_q - 1'b1;

    assign empty = (depth_q == '0);
    assign full  = (depth_q == CAP);
    assign depth = depth_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign T     = empty ? '0 : mem_q[sp_q];
    assign N     = (depth_q < TWO) ? '0 : mem_q[sp_m1];

    always_comb begin
        ovf_err = (delta == 2'b01) && full;
        unf_err = ((delta == 2'b11) && empty)
               || ((delta == 2'b10) && (depth_q < TWO))
               || ((delta == 2'b00) && update && empty);
`ifdef STACK_GUARD_EN
        move      = !(ovf_err || unf_err);
        depth_nxt = depth_q + depth_step;
`else
        // Legacy pointer keeps moving; only the depth counter saturates.
        move      = 1'b1;
        depth_nxt = ovf_err ? depth_q : (unf_err ? '0 : depth_q + depth_step);
`endif
        sp_d    = sp_q;
        depth_d = depth_q;
        wr_en   = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (!wait_state) begin
            if (move) begin
                sp_d    = sp_q + sp_step;
                depth_d = depth_nxt;
                wr_en   = update;
            end
            ovf_d = ovf_err || (ovf_q && !clr_err);
            unf_d = unf_err || (unf_q && !clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is never cleared; the depth masks on T/N hide stale words.
    always_ff @(posedge clk) begin
        if (wr_en && !reset)
            mem_q[sp_d] <= D;
    end
endmodule

// File: doc/dstack_guarded.md
# dstack_guarded

Parametrised successor to the CPU's return/data stack: a LIFO of `2**saddr_width` words with a signed per-cycle pointer step (+1, 0, −1, −2), two read taps (top and next), an exact occupancy counter, and sticky overflow/underflow flags. It sits between the Forth core's decode stage and its ALU. The core sees TOS/NOS directly, so `2DROP`, `NIP` and similar words complete in one cycle. Motion is stalled by the core's `wait_state`, as for the existing stacks.

## Interface
- `saddr_width`, 8: pointer width; capacity is `2**saddr_width` entries.
- `width`, 16: data word width.

- `clk`: in, 1. Single clock; all state changes on its rising edge.
- `reset`: in, 1. Synchronous, active-high.
- `wait_state`: in, 1. When high, no state changes this cycle.
- `D`: in, `width`. Word written to the new top when `update` is high.
- `delta`: in, 2. Two's-complement pointer step: 01 = +1, 00 = 0, 11 = −1, 10 = −2.
- `update`: in, 1. Write `D` at the post-step top.
- `clr_err`: in, 1. Clears `ovf`/`unf`.
- `T`: out, `width`. Top of stack; 0 when `depth == 0`.
- `N`: out, `width`. Next-on-stack; 0 when `depth < 2`.
- `depth`: out, `saddr_width+1`. Valid entry count, 0..`2**saddr_width`.
- `empty`: out, 1. `depth == 0`.
- `full`: out, 1. `depth == 2**saddr_width`.
- `ovf`: out, 1. Sticky overflow flag.
- `unf`: out, 1. Sticky underflow flag.

## Operation
- **State:** `SP` (`saddr_width` bits), `depth`, `ovf`, `unf`, and memory `mem[0 .. 2**saddr_width-1]`.
- **Read taps:** `T = mem[SP]` and `N = mem[SP-1]`, read combinationally and masked to 0 per the depth rules above. `SP-1` wraps modulo `2**saddr_width`.
- **Accepted cycle** (`!wait_state`, `!reset`):
  - `SP' = SP + sext(delta)`, modulo `2**saddr_width`.
  - `depth' = depth + sext(delta)`.
  - If `update`: `mem[SP'] <= D`.
- **Overflow:** `delta == +1` and `full`.
- **Underflow:** any of
  - `delta == −1` and `depth == 0`;
  - `delta == −2` and `depth < 2`;
  - `delta == 0` and `update` and `depth == 0` (replace on empty).
- **Error flags:** an error cycle sets the matching sticky flag. `clr_err` clears both flags. If `clr_err` and a new error occur in the same cycle, set wins for the erroring flag.
- **`wait_state` high:** `SP`, `depth`, `mem`, `ovf`, `unf` all hold. `clr_err` is ignored.
- **Reset:** `SP = 0`, `depth = 0`, `ovf = unf = 0`. Memory contents are not cleared, but `T`/`N` read 0 via masking. Reset overrides any operation or wait in the same cycle.
- **`update` with `delta == 0`:** replaces the top; `depth` is unchanged.

## Timing
- Step and write take effect at the edge ending the accepted cycle.
- New `T`, `N`, `depth`, `empty`, `full`, `ovf`, `unf` are visible in the following cycle.
- Read taps are combinational from registered `SP`/`depth` (zero-latency read).
- No handshake: every non-wait cycle is accepted.
- The pointer adder is a plain `saddr_width`-bit add of the sign-extended `delta`. The depth adder is `saddr_width+1` bits.

## Configuration
- `STACK_GUARD_EN` **defined:**
  - An overflow/underflow cycle is suppressed: `SP`, `depth` and `mem` are unchanged.
  - The matching flag is set.
- `STACK_GUARD_EN` **undefined:**
  - `SP` moves and wraps unconditionally, and the write always happens, matching legacy stack behaviour.
  - `depth` saturates at 0 and `2**saddr_width` instead of wrapping.
  - `ovf` and `unf` are still detected and set.

## Test plan
- **Push/read:** reset, then push 0x1111 and 0x2222 (`delta=01`, `update=1`) → `T=0x2222`, `N=0x1111`, `depth=2`, `empty=0`.
- **Double drop:** from 3 entries {A,B,C}, apply `delta=10` → next cycle `T=A`, `N=0`, `depth=1`; `unf=0`.
- **Underflow:** with `depth=1`, apply `delta=10`.
  - With guard: `depth` stays 1, `T` unchanged, `unf=1`.
  - Without guard: `depth=0`, `T=0`, `unf=1`.
- **Overflow:** with `saddr_width=2`, push 5 words → after the 5th, `ovf=1`.
  - With guard: `depth=4`, `T` = 4th word.
  - Without guard: `depth=4`, `T` = 5th word (wrapped).
- **Stall and flag clear:** hold `wait_state=1` while pushing 0xBEEF → `depth` and `T` unchanged. Assert `clr_err` together with a new overflow → `ovf` remains 1. Assert `clr_err` alone next cycle → `ovf=0`, `unf=0`.
- **Replace/reset:** `delta=00`, `update=1`, `D=0x00AA` on `depth=2` → `T=0x00AA`, `N` unchanged. Assert `reset` with a push in the same cycle → `depth=0`, `T=0`, flags 0.
